// File: rtl/logic_gate_pipe.sv
// Multi-channel bitwise gate unit feeding a STAGES-deep valid/ready pipeline; LGP_PARITY_EN adds per-channel OUT_PARITY.
// Latency: result on OUT_DATA STAGES-1 edges after the accepting edge (2 cycles from presentation at STAGES=2).
// Backpressure: full skid-free chain, IN_READY drops only when every stage is full and OUT_READY=0.
module logic_gate_pipe #(
    parameter int WIDTH  = 4,
    parameter int CH     = 3,
    parameter int STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CH*WIDTH-1:0]   IN_A,
    input  logic [CH*WIDTH-1:0]   IN_B,
    input  logic [3*CH-1:0]       OP,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [CH*WIDTH-1:0]   OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [15:0]           XFER_CNT
`ifdef LGP_PARITY_EN
    ,
    output logic [CH-1:0]         OUT_PARITY
`endif
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("logic_gate_pipe: STAGES must be in 1..4");
    end

    typedef struct packed {
        logic [CH*WIDTH-1:0] dat;
`ifdef LGP_PARITY_EN
        logic [CH-1:0]       par;
`endif
    } pay_t;

    function automatic logic [WIDTH-1:0] gate_fn(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0]       op);
        case (op)
            3'd0: gate_fn = a & b;
            3'd1: gate_fn = a | b;
            3'd2: gate_fn = ~(a & b);
            3'd3: gate_fn = ~(a | b);
            3'd4: gate_fn = a ^ b;
            3'd5: gate_fn = ~(a ^ b);
            3'd6: gate_fn = ~a;
            3'd7: gate_fn = a;
        endcase
    endfunction

    pay_t                    gate_res;
    pay_t [STAGES-1:0]       pay_q, pay_d;
    logic [STAGES-1:0]       vld_q, vld_d;
    logic [STAGES-1:0]       load;
    logic [15:0]             xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        gate_res = '0;
        for (int k = 0; k < CH; k++) begin
            gate_res.dat[k*WIDTH +: WIDTH] = gate_fn(IN_A[k*WIDTH +: WIDTH],
                                                     IN_B[k*WIDTH +: WIDTH],
                                                     OP[3*k +: 3]);
`ifdef LGP_PARITY_EN
            gate_res.par[k] = ^gate_res.dat[k*WIDTH +: WIDTH];
`endif
        end
    end

    // A stage can load unless it and every stage downstream of it is full
    // while the consumer stalls; this is the flattened form of the chain rule.
    always_comb begin
        load = '0;
        for (int i = 0; i < STAGES; i++) begin
            load[i] = (|(~vld_q >> i)) || OUT_READY;
        end
    end

    always_comb begin
        vld_d = vld_q;
        pay_d = pay_q;
        if (load[0]) begin
            vld_d[0] = IN_VALID;
            if (IN_VALID) begin
                pay_d[0] = gate_res;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    pay_d[i] = pay_q[i-1];
                end
            end
        end
        xfer_cnt_d = xfer_cnt_q + 16'(OUT_VALID && OUT_READY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q      <= '0;
            pay_q      <= '0;
            xfer_cnt_q <= '0;
        end else begin
            vld_q      <= vld_d;
            pay_q      <= pay_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign IN_READY  = load[0];
    assign OUT_VALID = vld_q[STAGES-1];
    assign OUT_DATA  = pay_q[STAGES-1].dat;
    assign XFER_CNT  = xfer_cnt_q;
`ifdef LGP_PARITY_EN
    assign OUT_PARITY = pay_q[STAGES-1].par;
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: queue-based reference model checked every cycle, plus directed literal vectors.
module tb_logic_gate_pipe;
    localparam int WIDTH  = 4;
    localparam int CH     = 3;
    localparam int STAGES = 2;
    localparam int DW     = CH*WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_a, in_b;
    logic [3*CH-1:0] op;
    logic            in_valid, in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid, out_ready;
    logic [15:0]     xfer_cnt;
`ifdef LGP_PARITY_EN
    logic [CH-1:0]   out_parity;
`endif

    logic_gate_pipe #(.WIDTH(WIDTH), .CH(CH), .STAGES(STAGES)) dut (
        .CLK(clk), .RST(rst), .IN_A(in_a), .IN_B(in_b), .OP(op),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .XFER_CNT(xfer_cnt)
`ifdef LGP_PARITY_EN
        , .OUT_PARITY(out_parity)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: each bit of each channel is the truth-table result of the op code.
    function automatic logic [DW-1:0] model_gate(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic [3*CH-1:0] o);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                logic x, y;
                x = a[k*WIDTH+j];
                y = b[k*WIDTH+j];
                case (o[3*k +: 3])
                    3'd0: r[k*WIDTH+j] = x & y;
                    3'd1: r[k*WIDTH+j] = x | y;
                    3'd2: r[k*WIDTH+j] = !(x & y);
                    3'd3: r[k*WIDTH+j] = !(x | y);
                    3'd4: r[k*WIDTH+j] = x != y;
                    3'd5: r[k*WIDTH+j] = x == y;
                    3'd6: r[k*WIDTH+j] = !x;
                    default: r[k*WIDTH+j] = x;
                endcase
            end
        end
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0] dat;
        int            acc;
    } ent_t;

    ent_t        mq[$];
    int          cyc = 0;
    logic [15:0] mcnt = '0;
    bit          chk_en = 0;

    // The oldest entry is visible once it has had STAGES-1 edges to travel.
    function automatic bit model_valid();
        return (mq.size() > 0) && ((cyc - mq[0].acc) >= STAGES-1);
    endfunction

    always @(posedge clk) begin
        bit pop, acc;
        if (rst) begin
            mq.delete();
            mcnt   = '0;
            chk_en = 1;
        end else begin
            pop = model_valid() && out_ready;
            acc = in_valid && ((mq.size() < STAGES) || out_ready);
            cyc++;
            if (pop) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (acc) mq.push_back('{model_gate(in_a, in_b, op), cyc});
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (chk_en) begin
            ev = model_valid();
            check("in_ready", 32'(in_ready), 32'((mq.size() < STAGES) || out_ready));
            check("out_valid", 32'(out_valid), 32'(ev));
            if (ev) check("out_data", 32'(out_data), 32'(mq[0].dat));
            check("xfer_cnt", 32'(xfer_cnt), 32'(mcnt));
`ifdef LGP_PARITY_EN
            if (ev) begin
                logic [CH-1:0] p;
                for (int k = 0; k < CH; k++) p[k] = ^mq[0].dat[k*WIDTH +: WIDTH];
                check("out_parity", 32'(out_parity), 32'(p));
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] iv_pat, or_pat;
        logic [2:0]  o3;
        bit          rdy_dropped;
        int          vcount;

        rst = 1; in_valid = 0; out_ready = 1; in_a = '0; in_b = '0; op = '0;
        tick(); tick();
        rst = 0;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_xfer_cnt", 32'(xfer_cnt), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // Single transaction: ch2 OR, ch1 NAND, ch0 NOR.
        in_a = 12'hA5C; in_b = 12'h3C6; op = {3'd1, 3'd2, 3'd3}; in_valid = 1;
        tick();
        in_valid = 0;
        check("lat_early_valid", 32'(out_valid), 0);
        tick();
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data", 32'(out_data), 32'h0BB1);
        tick();
        check("lat_xfer", 32'(xfer_cnt), 1);

        // Eight back-to-back, op cycling 0..7.
        rdy_dropped = 0; vcount = 0;
        for (int i = 0; i < 8; i++) begin
            o3 = 3'(i);
            op = {o3, o3, o3};
            in_a = 12'(12'h35B * (i + 1));
            in_b = 12'(12'h9C4 + i * 12'h111);
            in_valid = 1;
            if (!in_ready) rdy_dropped = 1;
            tick();
            if (out_valid) vcount++;
        end
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) vcount++;
        end
        check("stream_rdy_drop", 32'(rdy_dropped), 0);
        check("stream_vcount", 32'(vcount), 8);
        check("stream_xfer", 32'(xfer_cnt), 9);

        // Backpressure: two accepts with stalled output.
        out_ready = 0;
        in_a = 12'hFFF; in_b = 12'h0F0; op = '0; in_valid = 1;
        tick();
        op = {3'd4, 3'd4, 3'd4};
        tick();
        in_valid = 0;
        check("bp_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", 32'(out_data), 32'h00F0);
            tick();
        end
        out_ready = 1;
        #1;
        check("bp_ready_back", 32'(in_ready), 1);
        tick();
        check("bp_second", 32'(out_data), 32'h0F0F);
        check("bp_second_vld", 32'(out_valid), 1);
        tick();
        check("bp_drained", 32'(out_valid), 0);

        // Reset over a full pipeline, with a handshake offered at the reset edge.
        out_ready = 0; in_valid = 1; in_a = 12'h5A5; in_b = 12'h0FF; op = {3'd5, 3'd6, 3'd1};
        tick(); tick();
        rst = 1; out_ready = 1;
        tick();
        rst = 0; in_valid = 0;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_data", 32'(out_data), 0);
        check("mid_rst_xfer", 32'(xfer_cnt), 0);
        check("mid_rst_ready", 32'(in_ready), 1);
        tick(); tick();
        check("mid_rst_no_ghost", 32'(out_valid), 0);

        // Bubbles and intermittent stalls.
        iv_pat = 16'b1011_0110_1101_0011;
        or_pat = 16'b0110_1110_0101_1011;
        for (int i = 0; i < 16; i++) begin
            in_valid = iv_pat[i]; out_ready = or_pat[i];
            in_a = 12'(12'h1E7 + i * 12'h2B3); in_b = 12'(12'hC39 ^ (i * 12'h145));
            o3 = 3'(i); op = {o3, 3'(o3 + 3'd3), 3'(o3 + 3'd5)};
            tick();
        end
        in_valid = 0; out_ready = 1;
        repeat (4) tick();

        // Counter wrap.
        rst = 1; tick(); rst = 0;
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 65535 + STAGES; i++) begin
            in_a = 12'(i); in_b = 12'(i >> 3); op = 9'(i * 7);
            tick();
        end
        check("wrap_ffff", 32'(xfer_cnt), 32'hFFFF);
        in_valid = 0;
        tick();
        check("wrap_zero", 32'(xfer_cnt), 0);
        repeat (STAGES) tick();

`ifdef LGP_PARITY_EN
        in_a = 12'h731; in_b = '0; op = 9'o777; in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        check("par_valid", 32'(out_valid), 1);
        check("par_data", 32'(out_data), 32'h0731);
        check("par_bits", 32'(out_parity), 32'b101);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
